// File: rtl/nonlinear_net.sv
// Fixed-point three-layer perceptron, signed Q(WIDTH-16).16 throughout.
// NIN inputs -> NOUT1 ReLU neurons -> NOUT2 ReLU neurons -> NOUT linear outputs.
// Each layer is a single register stage. Weights and biases are constants,
// so every multiplier has one constant operand. A valid bit travels with
// the data.

// One fully connected layer: combinational multiply-accumulate, then a
// register stage. Weight W[i][j] (neuron i, input j) sits at
// W_FLAT[(N_IN*N_OUT-(i*N_IN+j))*WIDTH-1 -: WIDTH], so W[0][0] is in the MSBs.
// Bias b[i] sits at B_FLAT[(N_OUT-1-i)*WIDTH +: WIDTH], so b[0] is in the MSBs.
module nonlinear_layer #(
  parameter int WIDTH = 32,
  parameter int N_IN  = 2,
  parameter int N_OUT = 16,
  parameter bit RELU  = 1'b1,
  parameter logic [WIDTH*N_IN*N_OUT-1:0] W_FLAT = '0,
  parameter logic [WIDTH*N_OUT-1:0]      B_FLAT = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] act_i [0:N_IN-1],
  output logic             valid_o,
  output logic [WIDTH-1:0] act_o [0:N_OUT-1]
);

  // Products and sums are kept at double width. The sum is only narrowed
  // after the binary point has been realigned.
  localparam int PW   = 2 * WIDTH;
  localparam int FRAC = 16;

  logic [WIDTH-1:0] act_d [0:N_OUT-1];
  logic [WIDTH-1:0] act_q [0:N_OUT-1];
  logic             valid_q;

  function automatic logic signed [PW-1:0] sext(input logic [WIDTH-1:0] v);
    return $signed({{WIDTH{v[WIDTH-1]}}, v});
  endfunction

  // Full-precision signed product. The true product of two WIDTH-bit
  // signed values always fits in PW bits.
  function automatic logic signed [PW-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b);
    return sext(a) * sext(b);
  endfunction

  for (genvar i = 0; i < N_OUT; i++) begin : g_neuron
    localparam logic [WIDTH-1:0] BIAS = B_FLAT[(N_OUT-1-i)*WIDTH +: WIDTH];

    logic [WIDTH-1:0] pre_act;

    // Accumulate as a chain of per-input partial sums. Each partial sum is
    // its own net, so the chain has no combinational self-reference.
    for (genvar j = 0; j < N_IN; j++) begin : g_mac
      localparam logic [WIDTH-1:0] WEIGHT =
        W_FLAT[(N_IN*N_OUT-(i*N_IN+j))*WIDTH-1 -: WIDTH];
      logic signed [PW-1:0] acc;
      if (j == 0) begin : g_first
        assign acc = mul_full(WEIGHT, act_i[j]);
      end else begin : g_rest
        assign acc = g_mac[j-1].acc + mul_full(WEIGHT, act_i[j]);
      end
    end

    // Arithmetic shift rounds toward -inf. The bias is then added and the
    // result wraps to WIDTH bits; there is no saturation.
    assign pre_act = WIDTH'((g_mac[N_IN-1].acc >>> FRAC) + sext(BIAS));

    if (RELU) begin : g_relu
      assign act_d[i] = pre_act[WIDTH-1] ? '0 : pre_act;
    end else begin : g_linear
      assign act_d[i] = pre_act;
    end
  end

  // Stage register. Data loads every cycle; valid marks the cycles that matter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      // NOTE: the data array is cleared as well, not only the valid bit,
      // so the outputs read all-zero the moment reset is applied.
      act_q   <= '{default: '0};
    end else begin
      // NOTE: non-blocking assignments let every stage sample the previous
      // stage's old value on the same edge. That is what makes this a pipeline.
      valid_q <= valid_i;
      act_q   <= act_d;
    end
  end

  assign valid_o = valid_q;
  assign act_o   = act_q;

endmodule

// Top level: three layers in series, for a latency of three clock edges.
module nonlinear_net #(
  parameter int WIDTH = 32,
  parameter int NIN   = 2,
  parameter int NOUT1 = 16,
  parameter int NOUT2 = 4,
  parameter int NOUT  = 2,
  parameter logic [WIDTH*NIN*NOUT1-1:0]   WEIGHTS_MATRIX_FLAT1 = '0,
  parameter logic [WIDTH*NOUT1-1:0]       BIAS_FLAT1           = '0,
  parameter logic [WIDTH*NOUT1*NOUT2-1:0] WEIGHTS_MATRIX_FLAT2 = '0,
  parameter logic [WIDTH*NOUT2-1:0]       BIAS_FLAT2           = '0,
  parameter logic [WIDTH*NOUT2*NOUT-1:0]  WEIGHTS_MATRIX_FLAT3 = '0,
  parameter logic [WIDTH*NOUT-1:0]        BIAS_FLAT3           = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in  [0:NIN-1],
  output logic             out_valid,
  output logic [WIDTH-1:0] out [0:NOUT-1]
);

  logic             h1_valid_q;
  logic [WIDTH-1:0] h1_q [0:NOUT1-1];
  logic             h2_valid_q;
  logic [WIDTH-1:0] h2_q [0:NOUT2-1];

  // Stage 1: inputs to the first hidden layer (ReLU).
  nonlinear_layer #(
    .WIDTH (WIDTH), .N_IN(NIN), .N_OUT(NOUT1), .RELU(1'b1),
    .W_FLAT(WEIGHTS_MATRIX_FLAT1), .B_FLAT(BIAS_FLAT1)
  ) u_layer1 (
    .clk    (clk),
    .rst    (rst),
    .valid_i(in_valid),
    .act_i  (in),
    .valid_o(h1_valid_q),
    .act_o  (h1_q)
  );

  // Stage 2: first hidden layer to the second hidden layer (ReLU).
  nonlinear_layer #(
    .WIDTH (WIDTH), .N_IN(NOUT1), .N_OUT(NOUT2), .RELU(1'b1),
    .W_FLAT(WEIGHTS_MATRIX_FLAT2), .B_FLAT(BIAS_FLAT2)
  ) u_layer2 (
    .clk    (clk),
    .rst    (rst),
    .valid_i(h1_valid_q),
    .act_i  (h1_q),
    .valid_o(h2_valid_q),
    .act_o  (h2_q)
  );

  // Stage 3: second hidden layer to the linear outputs, which may be negative.
  nonlinear_layer #(
    .WIDTH (WIDTH), .N_IN(NOUT2), .N_OUT(NOUT), .RELU(1'b0),
    .W_FLAT(WEIGHTS_MATRIX_FLAT3), .B_FLAT(BIAS_FLAT3)
  ) u_layer3 (
    .clk    (clk),
    .rst    (rst),
    .valid_i(h2_valid_q),
    .act_i  (h2_q),
    .valid_o(out_valid),
    .act_o  (out)
  );

endmodule

// File: tb/tb_nonlinear_net.sv
// Testbench for nonlinear_net. Four instances cover different parameter sets:
//   u_main : default sizes, pseudo-random weights and biases (reference model)
//   u_zero : default sizes, zero weights, output biases (15276, -23962)
//   u_id   : 2-2-2-2 network, identity weights, zero biases
//   u_neg  : 2-2-2-2 network, identity W1/W2, W3 diagonal = -0.5
module tb_nonlinear_net;

  localparam int W = 32;

  // Deterministic word generator for the u_main constants. Each word is a
  // signed value in [-65536, 65535], i.e. roughly -1.0 .. +1.0 in Q16.16.
  function automatic logic [2047:0] gen_words(input int unsigned seed, input int n);
    logic [2047:0] v;
    int unsigned   s;
    int            w;
    v = '0;
    s = seed;
    for (int k = 0; k < n; k++) begin
      s = s * 32'd1103515245 + 32'd12345;
      w = int'({15'd0, s[31:15]}) - 65536;
      v[k*32 +: 32] = w;
    end
    return v;
  endfunction

  localparam logic [2047:0] W1_ALL = gen_words(32'd11, 32);
  localparam logic [2047:0] B1_ALL = gen_words(32'd23, 16);
  localparam logic [2047:0] W2_ALL = gen_words(32'd37, 64);
  localparam logic [2047:0] B2_ALL = gen_words(32'd41, 4);
  localparam logic [2047:0] W3_ALL = gen_words(32'd53, 8);
  localparam logic [2047:0] B3_ALL = gen_words(32'd67, 2);

  localparam logic [63:0]  ZERO_B3 = {32'd15276, 32'hFFFF_A266};
  localparam logic [127:0] W_ID    = {32'd65536, 32'd0, 32'd0, 32'd65536};
  localparam logic [127:0] W_NEG   = {32'hFFFF_8000, 32'd0, 32'd0, 32'hFFFF_8000};

  logic clk, rst;
  logic m_vld, m_ov, z_vld, z_ov, i_vld, i_ov, n_vld, n_ov;
  logic [W-1:0] m_in [0:1];
  logic [W-1:0] m_out [0:1];
  logic [W-1:0] z_in [0:1];
  logic [W-1:0] z_out [0:1];
  logic [W-1:0] i_in [0:1];
  logic [W-1:0] i_out [0:1];
  logic [W-1:0] n_in [0:1];
  logic [W-1:0] n_out [0:1];

  int checks   = 0;
  int failures = 0;

  // Reference-model weights, unpacked from the parameter vectors.
  int w1 [16][2];
  int b1 [16];
  int w2 [4][16];
  int b2 [4];
  int w3 [2][4];
  int b3 [2];

  nonlinear_net #(
    .WEIGHTS_MATRIX_FLAT1(W1_ALL[1023:0]), .BIAS_FLAT1(B1_ALL[511:0]),
    .WEIGHTS_MATRIX_FLAT2(W2_ALL[2047:0]), .BIAS_FLAT2(B2_ALL[127:0]),
    .WEIGHTS_MATRIX_FLAT3(W3_ALL[255:0]),  .BIAS_FLAT3(B3_ALL[63:0])
  ) u_main (
    .clk(clk), .rst(rst), .in_valid(m_vld), .in(m_in), .out_valid(m_ov), .out(m_out)
  );

  nonlinear_net #(.BIAS_FLAT3(ZERO_B3)) u_zero (
    .clk(clk), .rst(rst), .in_valid(z_vld), .in(z_in), .out_valid(z_ov), .out(z_out)
  );

  nonlinear_net #(
    .NIN(2), .NOUT1(2), .NOUT2(2), .NOUT(2),
    .WEIGHTS_MATRIX_FLAT1(W_ID), .WEIGHTS_MATRIX_FLAT2(W_ID), .WEIGHTS_MATRIX_FLAT3(W_ID)
  ) u_id (
    .clk(clk), .rst(rst), .in_valid(i_vld), .in(i_in), .out_valid(i_ov), .out(i_out)
  );

  nonlinear_net #(
    .NIN(2), .NOUT1(2), .NOUT2(2), .NOUT(2),
    .WEIGHTS_MATRIX_FLAT1(W_ID), .WEIGHTS_MATRIX_FLAT2(W_ID), .WEIGHTS_MATRIX_FLAT3(W_NEG)
  ) u_neg (
    .clk(clk), .rst(rst), .in_valid(n_vld), .in(n_in), .out_valid(n_ov), .out(n_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic int rand_q16();
    return int'($urandom_range(0, 1048575)) - 524288;
  endfunction

  task automatic load_model();
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 2; j++) w1[i][j] = W1_ALL[(32-(i*2+j))*32-1 -: 32];
      b1[i] = B1_ALL[(15-i)*32 +: 32];
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 16; j++) w2[i][j] = W2_ALL[(64-(i*16+j))*32-1 -: 32];
      b2[i] = B2_ALL[(3-i)*32 +: 32];
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) w3[i][j] = W3_ALL[(8-(i*4+j))*32-1 -: 32];
      b3[i] = B3_ALL[(1-i)*32 +: 32];
    end
  endtask

  // Behavioural network: 64-bit products and sums, floor shift, bias added,
  // wrap to 32 bits, ReLU on the hidden layers.
  task automatic model_net(input int x0, input int x1, output int y0, output int y1);
    int     x [2];
    int     a [16];
    int     h [4];
    int     y [2];
    longint s;
    int     r;
    x[0] = x0;
    x[1] = x1;
    for (int i = 0; i < 16; i++) begin
      s = 0;
      for (int j = 0; j < 2; j++) s += longint'(w1[i][j]) * longint'(x[j]);
      r = int'((s >>> 16) + longint'(b1[i]));
      a[i] = (r < 0) ? 0 : r;
    end
    for (int i = 0; i < 4; i++) begin
      s = 0;
      for (int j = 0; j < 16; j++) s += longint'(w2[i][j]) * longint'(a[j]);
      r = int'((s >>> 16) + longint'(b2[i]));
      h[i] = (r < 0) ? 0 : r;
    end
    for (int i = 0; i < 2; i++) begin
      s = 0;
      for (int j = 0; j < 4; j++) s += longint'(w3[i][j]) * longint'(h[j]);
      y[i] = int'((s >>> 16) + longint'(b3[i]));
    end
    y0 = y[0];
    y1 = y[1];
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({m_ov, z_ov, i_ov, n_ov} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_valid: got %b expected 0000", {m_ov, z_ov, i_ov, n_ov});
    end
    checks++;
    if (m_out[0] !== 0 || m_out[1] !== 0 || z_out[0] !== 0 || z_out[1] !== 0) begin
      failures++;
      $display("FAIL reset_data: got %0h %0h %0h %0h expected 0", m_out[0], m_out[1], z_out[0], z_out[1]);
    end
  endtask

  task automatic test_bias_only();
    @(negedge clk);
    z_in[0] = rand_q16();
    z_in[1] = rand_q16();
    z_vld   = 1'b1;
    @(negedge clk);
    z_vld   = 1'b0;
    z_in[0] = rand_q16();
    for (int e = 1; e <= 5; e++) begin
      if (e > 1) @(negedge clk);
      checks++;
      if (z_ov !== (e == 3)) begin
        failures++;
        $display("FAIL bias_valid edge%0d: got %b expected %b", e, z_ov, (e == 3));
      end
      if (e == 3) begin
        checks++;
        if (z_out[0] !== 32'd15276 || z_out[1] !== 32'hFFFF_A266) begin
          failures++;
          $display("FAIL bias_data: got %0d %0d expected 15276 -23962", $signed(z_out[0]), $signed(z_out[1]));
        end
      end
    end
  endtask

  // Two back-to-back samples through the identity network.
  task automatic test_identity();
    @(negedge clk);
    i_in[0] = 32'd131072;
    i_in[1] = -32'sd65536;
    i_vld   = 1'b1;
    @(negedge clk);
    i_in[0] = -32'sd5;
    i_in[1] = -32'sd5;
    @(negedge clk);
    i_vld   = 1'b0;
    i_in[0] = 32'd777;
    for (int e = 2; e <= 5; e++) begin
      if (e > 2) @(negedge clk);
      checks++;
      if (i_ov !== (e == 3 || e == 4)) begin
        failures++;
        $display("FAIL ident_valid edge%0d: got %b expected %b", e, i_ov, (e == 3 || e == 4));
      end
      if (e == 3) begin
        checks++;
        if (i_out[0] !== 32'd131072 || i_out[1] !== 32'd0) begin
          failures++;
          $display("FAIL ident_relu: got %0d %0d expected 131072 0", $signed(i_out[0]), $signed(i_out[1]));
        end
      end
      if (e == 4) begin
        checks++;
        if (i_out[0] !== 32'd0 || i_out[1] !== 32'd0) begin
          failures++;
          $display("FAIL ident_neg: got %0d %0d expected 0 0", $signed(i_out[0]), $signed(i_out[1]));
        end
      end
    end
  endtask

  task automatic test_floor_shift();
    @(negedge clk);
    n_in[0] = 32'd3;
    n_in[1] = 32'd0;
    n_vld   = 1'b1;
    @(negedge clk);
    n_vld   = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (n_ov !== 1'b1 || n_out[0] !== 32'hFFFF_FFFE || n_out[1] !== 32'd0) begin
      failures++;
      $display("FAIL floor_shift: got v=%b %0d %0d expected v=1 -2 0", n_ov, $signed(n_out[0]), $signed(n_out[1]));
    end
  endtask

  task automatic test_single_pulse();
    int ex0, ex1;
    model_net(-131072, -65536, ex0, ex1);
    @(negedge clk);
    m_in[0] = -32'sd131072;
    m_in[1] = -32'sd65536;
    m_vld   = 1'b1;
    @(negedge clk);
    m_vld   = 1'b0;
    m_in[0] = rand_q16();
    m_in[1] = rand_q16();
    for (int e = 1; e <= 5; e++) begin
      if (e > 1) @(negedge clk);
      checks++;
      if (m_ov !== (e == 3)) begin
        failures++;
        $display("FAIL pulse_valid edge%0d: got %b expected %b", e, m_ov, (e == 3));
      end
      if (e == 3) begin
        checks++;
        if (m_out[0] !== ex0 || m_out[1] !== ex1) begin
          failures++;
          $display("FAIL pulse_data: got %0d %0d expected %0d %0d", $signed(m_out[0]), $signed(m_out[1]), ex0, ex1);
        end
      end
    end
  endtask

  // Random stream with a back-to-back burst at the start, then random gaps.
  task automatic test_back_to_back();
    localparam int N = 60;
    bit ev [0:N+2];
    int e0 [0:N+2];
    int e1 [0:N+2];
    int x0, x1;
    for (int c = 0; c <= N + 2; c++) begin
      @(negedge clk);
      checks++;
      if (m_ov !== ((c >= 3) ? ev[c-3] : 1'b0)) begin
        failures++;
        $display("FAIL stream_valid cyc%0d: got %b expected %b", c, m_ov, (c >= 3) ? ev[c-3] : 1'b0);
      end
      if (c >= 3 && ev[c-3]) begin
        checks++;
        if (m_out[0] !== e0[c-3] || m_out[1] !== e1[c-3]) begin
          failures++;
          $display("FAIL stream_data cyc%0d: got %0d %0d expected %0d %0d", c, $signed(m_out[0]), $signed(m_out[1]), e0[c-3], e1[c-3]);
        end
      end
      x0 = rand_q16();
      x1 = rand_q16();
      ev[c] = (c < N) && ((c < 10) || ($urandom_range(0, 3) != 0));
      model_net(x0, x1, e0[c], e1[c]);
      m_in[0] = x0;
      m_in[1] = x1;
      m_vld   = ev[c];
    end
    m_vld = 1'b0;
  endtask

  task automatic test_async_reset();
    int x0 [6];
    int x1 [6];
    int e0 [6];
    int e1 [6];
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (m_ov !== (c >= 3)) begin
        failures++;
        $display("FAIL arst_pre_valid cyc%0d: got %b expected %b", c, m_ov, (c >= 3));
      end
      if (c >= 3) begin
        checks++;
        if (m_out[0] !== e0[c-3] || m_out[1] !== e1[c-3]) begin
          failures++;
          $display("FAIL arst_pre_data cyc%0d: got %0d %0d expected %0d %0d", c, $signed(m_out[0]), $signed(m_out[1]), e0[c-3], e1[c-3]);
        end
      end
      x0[c] = rand_q16();
      x1[c] = rand_q16();
      model_net(x0[c], x1[c], e0[c], e1[c]);
      m_in[0] = x0[c];
      m_in[1] = x1[c];
      m_vld   = (c < 5);
    end
    // Assert reset between edges; outputs must clear before the next edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (m_ov !== 1'b0 || m_out[0] !== 0 || m_out[1] !== 0) begin
      failures++;
      $display("FAIL arst_immediate: got v=%b %0h %0h expected v=0 0 0", m_ov, m_out[0], m_out[1]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (m_ov !== 1'b0) begin
        failures++;
        $display("FAIL arst_stale cyc%0d: got %b expected 0", k, m_ov);
      end
    end
    model_net(x0[0] ^ 32'h0001_2345, x1[1], e0[0], e1[0]);
    m_in[0] = x0[0] ^ 32'h0001_2345;
    m_in[1] = x1[1];
    m_vld   = 1'b1;
    @(negedge clk);
    m_vld   = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      if (e > 1) @(negedge clk);
      checks++;
      if (m_ov !== (e == 3)) begin
        failures++;
        $display("FAIL arst_post_valid edge%0d: got %b expected %b", e, m_ov, (e == 3));
      end
      if (e == 3) begin
        checks++;
        if (m_out[0] !== e0[0] || m_out[1] !== e1[0]) begin
          failures++;
          $display("FAIL arst_post_data: got %0d %0d expected %0d %0d", $signed(m_out[0]), $signed(m_out[1]), e0[0], e1[0]);
        end
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    m_vld = 1'b0;
    z_vld = 1'b0;
    i_vld = 1'b0;
    n_vld = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_in[k] = 32'h1234_5678;
      z_in[k] = 32'h0;
      i_in[k] = 32'h0;
      n_in[k] = 32'h0;
    end
    load_model();
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_bias_only();
    test_identity();
    test_floor_shift();
    test_single_pulse();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
